// File: rtl/axi_arbiter_if.sv
// AXI4 channel bundle shared by the arbiter's master-side ports and its downstream port.
// Carries only the fields the arbiter forwards: address/length, data/strobe/last, response.
interface axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input awaddr, awlen, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_arbiter.sv
// Two-master to one-slave AXI arbiter with exactly one transaction in flight downstream.
// Handshakes: a beat moves on a channel only in a cycle where both valid and ready are high.
module axi_arbiter #(
  parameter bit RR_EN       = 1'b1,
  parameter bit FIRST_GRANT = 1'b0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_if.slave       s_axi0,
  axi_if.slave       s_axi1,
  axi_if.master      m_axi,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WDATA = 3'd4,
    S_WRESP = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic                own_arvalid, own_rready, own_awvalid, own_wvalid, own_wlast, own_bready;
  logic [ADDR_W-1:0]   own_araddr, own_awaddr;
  logic [7:0]          own_arlen, own_awlen;
  logic [DATA_W-1:0]   own_wdata;
  logic [DATA_W/8-1:0] own_wstrb;

  logic                to_arready, to_awready, to_wready, to_rvalid, to_rlast, to_bvalid;
  logic [DATA_W-1:0]   to_rdata;
  logic [1:0]          to_rresp, to_bresp;

  logic req0, req1, pref, winner, win_rd;

  always_comb begin
    if (owner_q) begin
      own_arvalid = s_axi1.arvalid;
      own_araddr  = s_axi1.araddr;
      own_arlen   = s_axi1.arlen;
      own_rready  = s_axi1.rready;
      own_awvalid = s_axi1.awvalid;
      own_awaddr  = s_axi1.awaddr;
      own_awlen   = s_axi1.awlen;
      own_wvalid  = s_axi1.wvalid;
      own_wdata   = s_axi1.wdata;
      own_wstrb   = s_axi1.wstrb;
      own_wlast   = s_axi1.wlast;
      own_bready  = s_axi1.bready;
    end else begin
      own_arvalid = s_axi0.arvalid;
      own_araddr  = s_axi0.araddr;
      own_arlen   = s_axi0.arlen;
      own_rready  = s_axi0.rready;
      own_awvalid = s_axi0.awvalid;
      own_awaddr  = s_axi0.awaddr;
      own_awlen   = s_axi0.awlen;
      own_wvalid  = s_axi0.wvalid;
      own_wdata   = s_axi0.wdata;
      own_wstrb   = s_axi0.wstrb;
      own_wlast   = s_axi0.wlast;
      own_bready  = s_axi0.bready;
    end
  end

  // Only the channel belonging to the current state is connected; everything else is held at 0.
  always_comb begin
    m_axi.arvalid = 1'b0;
    m_axi.araddr  = '0;
    m_axi.arlen   = '0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.awaddr  = '0;
    m_axi.awlen   = '0;
    m_axi.wvalid  = 1'b0;
    m_axi.wdata   = '0;
    m_axi.wstrb   = '0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    to_arready    = 1'b0;
    to_awready    = 1'b0;
    to_wready     = 1'b0;
    to_rvalid     = 1'b0;
    to_rdata      = '0;
    to_rresp      = '0;
    to_rlast      = 1'b0;
    to_bvalid     = 1'b0;
    to_bresp      = '0;
    case (state_q)
      S_RADDR: begin
        m_axi.arvalid = own_arvalid;
        m_axi.araddr  = own_araddr;
        m_axi.arlen   = own_arlen;
        to_arready    = m_axi.arready;
      end
      S_RDATA: begin
        m_axi.rready = own_rready;
        to_rvalid    = m_axi.rvalid;
        to_rdata     = m_axi.rvalid ? m_axi.rdata : '0;
        to_rresp     = m_axi.rresp;
        to_rlast     = m_axi.rlast;
      end
      S_WADDR: begin
        m_axi.awvalid = own_awvalid;
        m_axi.awaddr  = own_awaddr;
        m_axi.awlen   = own_awlen;
        to_awready    = m_axi.awready;
      end
      S_WDATA: begin
        m_axi.wvalid = own_wvalid;
        m_axi.wdata  = own_wdata;
        m_axi.wstrb  = own_wstrb;
        m_axi.wlast  = own_wlast;
        to_wready    = m_axi.wready;
      end
      S_WRESP: begin
        m_axi.bready = own_bready;
        to_bvalid    = m_axi.bvalid;
        to_bresp     = m_axi.bresp;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_axi0.arready = to_arready & ~owner_q;
    s_axi0.awready = to_awready & ~owner_q;
    s_axi0.wready  = to_wready  & ~owner_q;
    s_axi0.rvalid  = to_rvalid  & ~owner_q;
    s_axi0.rdata   = owner_q ? '0 : to_rdata;
    s_axi0.rresp   = owner_q ? '0 : to_rresp;
    s_axi0.rlast   = to_rlast   & ~owner_q;
    s_axi0.bvalid  = to_bvalid  & ~owner_q;
    s_axi0.bresp   = owner_q ? '0 : to_bresp;
    s_axi1.arready = to_arready & owner_q;
    s_axi1.awready = to_awready & owner_q;
    s_axi1.wready  = to_wready  & owner_q;
    s_axi1.rvalid  = to_rvalid  & owner_q;
    s_axi1.rdata   = owner_q ? to_rdata : '0;
    s_axi1.rresp   = owner_q ? to_rresp : '0;
    s_axi1.rlast   = to_rlast   & owner_q;
    s_axi1.bvalid  = to_bvalid  & owner_q;
    s_axi1.bresp   = owner_q ? to_bresp : '0;
  end

  // Round-robin prefers whichever master did not finish the previous transaction.
  always_comb begin
    req0 = s_axi0.arvalid | s_axi0.awvalid;
    req1 = s_axi1.arvalid | s_axi1.awvalid;
    pref = ~last_q;
    if (RR_EN) begin
      winner = (pref ? req1 : req0) ? pref : ~pref;
    end else begin
      winner = ~req0;
    end
    win_rd = winner ? s_axi1.arvalid : s_axi0.arvalid;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          state_d = win_rd ? S_RADDR : S_WADDR;
        end
      end
      S_RADDR: if (own_arvalid && m_axi.arready) state_d = S_RDATA;
      S_RDATA: begin
        if (m_axi.rvalid && own_rready && m_axi.rlast) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      S_WADDR: if (own_awvalid && m_axi.awready) state_d = S_WDATA;
      S_WDATA: if (own_wvalid && m_axi.wready && own_wlast) state_d = S_WRESP;
      S_WRESP: begin
        if (m_axi.bvalid && own_bready) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= FIRST_GRANT;
      last_q  <= ~FIRST_GRANT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: round-robin instance on a RAM model, fixed-priority instance
// on a single-beat read responder that returns the address as data.
module tb_axi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_if a0 ();
  axi_if a1 ();
  axi_if am ();
  axi_if f0 ();
  axi_if f1 ();
  axi_if fm ();
  logic [2:0] dbg, fdbg;

  axi_arbiter #(.RR_EN(1'b1), .FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_axi0(a0), .s_axi1(a1), .m_axi(am), .dbg_state(dbg)
  );
  axi_arbiter #(.RR_EN(1'b0), .FIRST_GRANT(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .s_axi0(f0), .s_axi1(f1), .m_axi(fm), .dbg_state(fdbg)
  );

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  logic [1:0]  ss;
  logic [5:0]  s_idx;
  logic [7:0]  s_beat, s_len;

  assign am.arready = (ss == 2'd0);
  assign am.awready = (ss == 2'd0);
  assign am.rvalid  = (ss == 2'd1);
  assign am.rdata   = mem[s_idx];
  assign am.rresp   = 2'b01;
  assign am.rlast   = (ss == 2'd1) && (s_beat == s_len);
  assign am.wready  = (ss == 2'd2);
  assign am.bvalid  = (ss == 2'd3);
  assign am.bresp   = 2'b01;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss <= 2'd0;
      if (!mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= i * 32'h01010101;
        mem[4]   <= 32'hDEADBEEF;
        mem_init <= 1'b1;
      end
    end else begin
      case (ss)
        2'd0: begin
          if (am.arvalid) begin
            s_idx <= am.araddr[7:2]; s_len <= am.arlen; s_beat <= 8'd0; ss <= 2'd1;
          end else if (am.awvalid) begin
            s_idx <= am.awaddr[7:2]; s_len <= am.awlen; s_beat <= 8'd0; ss <= 2'd2;
          end
        end
        2'd1: begin
          if (am.rready) begin
            if (s_beat == s_len) ss <= 2'd0;
            else begin
              s_beat <= s_beat + 8'd1;
              s_idx  <= s_idx + 6'd1;
            end
          end
        end
        2'd2: begin
          if (am.wvalid) begin
            for (int b = 0; b < 4; b++)
              if (am.wstrb[b]) mem[s_idx][8*b +: 8] <= am.wdata[8*b +: 8];
            s_idx <= s_idx + 6'd1;
            if (am.wlast) ss <= 2'd3;
          end
        end
        default: if (am.bready) ss <= 2'd0;
      endcase
    end
  end

  // ---------------- fixed-priority side responder ----------------
  logic        fs_busy;
  logic [31:0] fs_data;
  assign fm.arready = !fs_busy;
  assign fm.rvalid  = fs_busy;
  assign fm.rdata   = fs_data;
  assign fm.rresp   = 2'b00;
  assign fm.rlast   = 1'b1;
  assign fm.awready = 1'b0;
  assign fm.wready  = 1'b0;
  assign fm.bvalid  = 1'b0;
  assign fm.bresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fs_busy <= 1'b0;
    else if (!fs_busy && fm.arvalid) begin
      fs_busy <= 1'b1;
      fs_data <= fm.araddr;
    end else if (fs_busy && fm.rready) fs_busy <= 1'b0;
  end

  // ---------------- monitor ----------------
  int          done_q[$];
  int          fdone_q[$];
  logic [31:0] rd0_q[$];
  logic [31:0] rd1_q[$];
  logic [31:0] fd1_q[$];
  logic [1:0]  rresp0, bresp1;
  logic        w1_busy = 1'b0;
  int          w1_beats = 0, hold_bad = 0, inv_bad = 0, s1_rv_cnt = 0, s0_b_cnt = 0;
  logic [4:0]  act0, act1;

  always @(negedge clk) begin
    act0 = {a0.arready, a0.awready, a0.wready, a0.rvalid, a0.bvalid};
    act1 = {a1.arready, a1.awready, a1.wready, a1.rvalid, a1.bvalid};
    if (a0.rvalid && a0.rready) begin
      rd0_q.push_back(a0.rdata);
      rresp0 <= a0.rresp;
      if (a0.rlast) done_q.push_back(0);
    end
    if (a1.rvalid && a1.rready) begin
      rd1_q.push_back(a1.rdata);
      if (a1.rlast) done_q.push_back(1);
    end
    if (a0.bvalid && a0.bready) done_q.push_back(2);
    if (a1.bvalid && a1.bready) begin
      done_q.push_back(3);
      bresp1  <= a1.bresp;
      w1_busy <= 1'b0;
    end else if (a1.awvalid && a1.awready) w1_busy <= 1'b1;
    if (a1.wvalid && a1.wready) w1_beats <= w1_beats + 1;
    if (a0.arready && w1_busy) hold_bad <= hold_bad + 1;
    if (a1.rvalid) s1_rv_cnt <= s1_rv_cnt + 1;
    if (a0.bvalid) s0_b_cnt <= s0_b_cnt + 1;
    if ((act0 != 5'd0 && act1 != 5'd0) || $countones(act0) > 1 || $countones(act1) > 1 ||
        (!a0.rvalid && a0.rdata != 32'd0) || (!a1.rvalid && a1.rdata != 32'd0))
      inv_bad <= inv_bad + 1;
    if (f0.rvalid && f0.rready && f0.rlast) fdone_q.push_back(10);
    if (f1.rvalid && f1.rready && f1.rlast) begin
      fdone_q.push_back(11);
      fd1_q.push_back(f1.rdata);
    end
  end

  // ---------------- scoreboard / checks ----------------
  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wdat [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int done_at(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction

  function automatic int fdone_at(input int i);
    return (i < fdone_q.size()) ? fdone_q[i] : -1;
  endfunction

  function automatic logic [31:0] rd0_at(input int i);
    return (i < rd0_q.size()) ? rd0_q[i] : 32'hBADBAD00;
  endfunction

  function automatic logic [31:0] rd1_at(input int i);
    return (i < rd1_q.size()) ? rd1_q[i] : 32'hBADBAD00;
  endfunction

  task automatic check_rd0(input string tag);
    chk({tag, "_beats"}, rd0_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk(tag, rd0_at(i), exp_q[i]);
    exp_q.delete();
  endtask

  task automatic clr();
    done_q.delete(); fdone_q.delete(); rd0_q.delete(); rd1_q.delete(); fd1_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic set_ar(input int m, input logic v, input logic [31:0] addr, input logic [7:0] len);
    case (m)
      0: begin a0.arvalid = v; a0.araddr = addr; a0.arlen = len; end
      1: begin a1.arvalid = v; a1.araddr = addr; a1.arlen = len; end
      2: begin f0.arvalid = v; f0.araddr = addr; f0.arlen = len; end
      default: begin f1.arvalid = v; f1.araddr = addr; f1.arlen = len; end
    endcase
  endtask

  function automatic logic ar_hs(input int m);
    case (m)
      0: return a0.arvalid && a0.arready;
      1: return a1.arvalid && a1.arready;
      2: return f0.arvalid && f0.arready;
      default: return f1.arvalid && f1.arready;
    endcase
  endfunction

  task automatic m_read(input int m, input logic [31:0] addr, input logic [7:0] len);
    int n;
    logic hs;
    n = 0;
    set_ar(m, 1'b1, addr, len);
    do begin
      @(negedge clk);
      n++;
      hs = ar_hs(m);
    end while (!hs && n < 300);
    chk("ar_handshake", hs, 1'b1);
    @(posedge clk); #1;
    set_ar(m, 1'b0, 32'd0, 8'd0);
  endtask

  task automatic m1_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb);
    int beat, n;
    logic aw_done;
    beat = 0; n = 0; aw_done = 1'b0;
    a1.awvalid = 1'b1; a1.awaddr = addr; a1.awlen = len;
    a1.wvalid = 1'b1; a1.wdata = wdat[0]; a1.wstrb = strb; a1.wlast = (len == 8'd0);
    while ((!aw_done || beat <= int'(len)) && n < 300) begin
      @(negedge clk);
      n++;
      if (a1.awvalid && a1.awready) aw_done = 1'b1;
      if (a1.wvalid && a1.wready) beat++;
      @(posedge clk); #1;
      if (aw_done) a1.awvalid = 1'b0;
      if (beat > int'(len)) a1.wvalid = 1'b0;
      else begin
        a1.wdata = wdat[beat];
        a1.wlast = (beat == int'(len));
      end
    end
    chk("w_beats", beat, int'(len) + 1);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_q.size() < n && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_count", done_q.size(), n);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int base, wb0, nw, rsz;

  initial begin
    a0.arvalid = 0; a0.araddr = 0; a0.arlen = 0; a0.rready = 1; a0.awvalid = 0; a0.awaddr = 0;
    a0.awlen = 0; a0.wvalid = 0; a0.wdata = 0; a0.wstrb = 0; a0.wlast = 0; a0.bready = 1;
    a1.arvalid = 0; a1.araddr = 0; a1.arlen = 0; a1.rready = 1; a1.awvalid = 0; a1.awaddr = 0;
    a1.awlen = 0; a1.wvalid = 0; a1.wdata = 0; a1.wstrb = 0; a1.wlast = 0; a1.bready = 1;
    f0.arvalid = 0; f0.araddr = 0; f0.arlen = 0; f0.rready = 1; f0.awvalid = 0; f0.awaddr = 0;
    f0.awlen = 0; f0.wvalid = 0; f0.wdata = 0; f0.wstrb = 0; f0.wlast = 0; f0.bready = 1;
    f1.arvalid = 0; f1.araddr = 0; f1.arlen = 0; f1.rready = 1; f1.awvalid = 0; f1.awaddr = 0;
    f1.awlen = 0; f1.wvalid = 0; f1.wdata = 0; f1.wstrb = 0; f1.wlast = 0; f1.bready = 1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", dbg, 3'd0);
    chk("rst_state_fp", fdbg, 3'd0);
    chk("rst_m_out", {am.arvalid, am.awvalid, am.wvalid, am.rready, am.bready}, 5'd0);
    chk("rst_s_out", {a0.arready, a0.awready, a0.wready, a0.rvalid, a0.bvalid,
                      a1.arready, a1.awready, a1.wready, a1.rvalid, a1.bvalid}, 10'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single read, one-cycle grant latency
    base = s1_rv_cnt;
    a0.arvalid = 1'b1; a0.araddr = 32'h80000010; a0.arlen = 8'd0;
    @(negedge clk);
    chk("idle_no_fwd", am.arvalid, 1'b0);
    chk("idle_no_ready", a0.arready, 1'b0);
    @(negedge clk);
    chk("ar_fwd", am.arvalid, 1'b1);
    chk("ar_addr", am.araddr, 32'h80000010);
    @(posedge clk); #1;
    a0.arvalid = 1'b0;
    wait_done(1);
    chk("read_owner", done_at(0), 0);
    exp_q.push_back(32'hDEADBEEF);
    check_rd0("read_data");
    chk("rresp_pass", rresp0, 2'b01);
    chk("s1_no_rvalid", s1_rv_cnt - base, 0);
    clr();

    // write from master 1, read back by master 0
    base = s0_b_cnt;
    wdat[0] = 32'h12345678;
    m1_write(32'h80000020, 8'd0, 4'hF);
    wait_done(1);
    chk("write_owner", done_at(0), 3);
    chk("s0_no_bvalid", s0_b_cnt - base, 0);
    chk("bresp_pass", bresp1, 2'b01);
    m_read(0, 32'h80000020, 8'd0);
    wait_done(2);
    exp_q.push_back(32'h12345678);
    check_rd0("readback");
    clr();

    // partial-strobe write merges bytes
    wdat[0] = 32'hAABBCCDD;
    m1_write(32'h80000020, 8'd0, 4'b0101);
    m_read(0, 32'h80000020, 8'd0);
    wait_done(2);
    exp_q.push_back(32'h12BB56DD);
    check_rd0("wstrb_merge");
    clr();

    // read/write tie with last grant on master 0: master 1 write first
    wdat[0] = 32'hCAFEF00D;
    fork
      m_read(0, 32'h80000010, 8'd0);
      m1_write(32'h80000044, 8'd0, 4'hF);
    join
    wait_done(2);
    chk("tie_first", done_at(0), 3);
    chk("tie_second", done_at(1), 0);
    exp_q.push_back(32'hDEADBEEF);
    check_rd0("tie_read");
    clr();

    // burst write holds off a master 0 read arriving in beat 2
    base = hold_bad;
    wb0 = w1_beats;
    wdat[0] = 32'h11111111; wdat[1] = 32'h22222222; wdat[2] = 32'h33333333; wdat[3] = 32'h44444444;
    fork
      m1_write(32'h80000050, 8'd3, 4'hF);
      begin
        nw = 0;
        while (w1_beats < wb0 + 1 && nw < 100) begin
          @(posedge clk); #1;
          nw++;
        end
        m_read(0, 32'h80000050, 8'd3);
      end
    join
    wait_done(2);
    chk("hold_off", hold_bad - base, 0);
    chk("burst_first", done_at(0), 3);
    chk("burst_second", done_at(1), 0);
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    check_rd0("burst_read");
    clr();

    // round-robin contention from reset
    pulse_reset();
    fork
      begin m_read(0, 32'h80000004, 8'd0); m_read(0, 32'h80000004, 8'd0); end
      begin m_read(1, 32'h80000008, 8'd0); m_read(1, 32'h80000008, 8'd0); end
    join
    wait_done(4);
    chk("rr_grant0", done_at(0), 0);
    chk("rr_grant1", done_at(1), 1);
    chk("rr_grant2", done_at(2), 0);
    chk("rr_grant3", done_at(3), 1);
    exp_q.push_back(32'h01010101); exp_q.push_back(32'h01010101);
    check_rd0("rr_m0_data");
    chk("rr_m1_data", rd1_at(1), 32'h02020202);
    clr();

    // fixed priority: master 0 wins all four while master 1 waits
    fork
      begin
        m_read(2, 32'h00000100, 8'd0); m_read(2, 32'h00000104, 8'd0);
        m_read(2, 32'h00000108, 8'd0); m_read(2, 32'h0000010C, 8'd0);
      end
      m_read(3, 32'h00000200, 8'd0);
    join
    nw = 0;
    while (fdone_q.size() < 5 && nw < 200) begin
      @(posedge clk); #1;
      nw++;
    end
    for (int i = 0; i < 4; i++) chk("fp_grant_m0", fdone_at(i), 10);
    chk("fp_grant_m1", fdone_at(4), 11);
    chk("fp_m1_data", (fd1_q.size() > 0) ? fd1_q[0] : 32'hBADBAD00, 32'h00000200);
    clr();

    // reset during a read burst aborts it
    m_read(0, 32'h80000050, 8'd3);
    nw = 0;
    while (rd0_q.size() < 1 && nw < 50) begin
      @(posedge clk); #1;
      nw++;
    end
    chk("abort_in_rdata", dbg, 3'd2);
    rst_n = 1'b0;
    rsz = rd0_q.size();
    #1;
    chk("abort_state", dbg, 3'd0);
    chk("abort_m_out", {am.arvalid, am.awvalid, am.wvalid, am.rready, am.bready}, 5'd0);
    chk("abort_s_out", {a0.arready, a0.awready, a0.wready, a0.rvalid, a0.bvalid,
                        a1.arready, a1.awready, a1.wready, a1.rvalid, a1.bvalid}, 10'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_beats", rd0_q.size(), rsz);
    chk("abort_no_done", done_q.size(), 0);
    clr();
    m_read(0, 32'h80000010, 8'd0);
    wait_done(1);
    chk("post_reset_owner", done_at(0), 0);
    exp_q.push_back(32'hDEADBEEF);
    check_rd0("post_reset_read");

    chk("channel_invariants", inv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
